pipe_stage_hs: RTL

//  Parametrised pipeline-stage register, successor to the fixed F/D/E/M/W latch set. Carries an

---
 rtl/pipe_stage_hs_pkg.sv | 18 +
 rtl/pipe_stage_hs_slot.sv | 18 +
 rtl/pipe_stage_hs.sv | 149 ++++++++++++++
 3 files changed

// File: rtl/pipe_stage_hs_pkg.sv
// Shared constants and state encoding for the valid/ready pipeline stage register.
package pipe_stage_hs_pkg;

  localparam int          EXC_W_DEF      = 5;
  localparam logic [31:0] RESET_PC_DEF   = 32'h0000_3000;
  localparam logic [31:0] HANDLER_PC_DEF = 32'h0000_4180;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } state_t;

  function automatic logic [31:0] wrap_inc(input logic [31:0] v);
    return v + 32'd1;
  endfunction

endpackage

// File: rtl/pipe_stage_hs_slot.sv
// One storage slot of the stage: a W-bit register with synchronous reset, clear and load.
module pipe_stage_hs_slot #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic         clear,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  always_ff @(posedge clk) begin
    if (reset || clear) q <= '0;
    else if (load)      q <= d;
  end

endmodule

// File: rtl/pipe_stage_hs.sv
// Pipeline stage register with a 2-entry skid buffer, exception flush and bubble insert.
// Optional statistics counters are built when PIPE_STATS_EN is defined.
module pipe_stage_hs
  import pipe_stage_hs_pkg::*;
#(
  parameter int          DATA_W     = 64,
  parameter int          EXC_W      = EXC_W_DEF,
  parameter logic [31:0] RESET_PC   = RESET_PC_DEF,
  parameter logic [31:0] HANDLER_PC = HANDLER_PC_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req,
  input  logic              kill,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [31:0]       in_pc,
  input  logic [EXC_W-1:0]  in_exc,
  input  logic              in_bd,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [31:0]       out_pc,
  output logic [EXC_W-1:0]  out_exc,
  output logic              out_bd,
  output logic [31:0]       stat_stall,
  output logic [31:0]       stat_kill
);

  localparam int SLOT_W = DATA_W + 32 + EXC_W + 1;

  state_t            state_p0, state_nx;
  logic [SLOT_W-1:0] in_beat, main_d, main_q, skid_q;
  logic              main_load, main_clr, skid_load, skid_clr;
  logic              acc, dq, kill_hs;
  logic [31:0]       bubble_pc;
  logic              bubble_bd;

  assign in_beat   = {in_data, in_pc, in_exc, in_bd};
  assign out_valid = (state_p0 != ST_EMPTY);
  assign acc       = in_valid && in_ready && !kill;
  assign dq        = out_valid && out_ready;
  assign kill_hs   = kill && in_valid && in_ready;

  always_comb begin
    state_nx  = state_p0;
    main_d    = in_beat;
    main_load = 1'b0;
    main_clr  = 1'b0;
    skid_load = 1'b0;
    skid_clr  = 1'b0;
    if (req) begin
      state_nx = ST_EMPTY;
      main_clr = 1'b1;
      skid_clr = 1'b1;
    end else begin
      unique case (state_p0)
        ST_EMPTY: if (acc) begin
          main_load = 1'b1;
          state_nx  = ST_ONE;
        end
        ST_ONE: begin
          if (acc && !dq) begin
            skid_load = 1'b1;
            state_nx  = ST_TWO;
          end else if (!acc && dq) begin
            main_clr = 1'b1;
            state_nx = ST_EMPTY;
          end else if (acc && dq) begin
            main_load = 1'b1;
          end
        end
        ST_TWO: if (dq) begin
          main_d    = skid_q;
          main_load = 1'b1;
          skid_clr  = 1'b1;
          state_nx  = ST_ONE;
        end
        default: state_nx = ST_EMPTY;
      endcase
    end
  end

  // State register, registered in_ready and bubble PC/BD tracking
  always_ff @(posedge clk) begin
    if (reset) begin
      state_p0  <= ST_EMPTY;
      in_ready  <= 1'b1;
      bubble_pc <= RESET_PC;
      bubble_bd <= 1'b0;
    end else begin
      state_p0 <= state_nx;
      in_ready <= (state_nx != ST_TWO);
      if (req) begin
        bubble_pc <= HANDLER_PC;
        bubble_bd <= 1'b0;
      end else if (kill_hs) begin
        bubble_pc <= in_pc;
        bubble_bd <= in_bd;
      end
    end
  end

  pipe_stage_hs_slot #(.W(SLOT_W)) u_main (
    .clk   (clk),
    .reset (reset),
    .load  (main_load),
    .clear (main_clr),
    .d     (main_d),
    .q     (main_q)
  );

  pipe_stage_hs_slot #(.W(SLOT_W)) u_skid (
    .clk   (clk),
    .reset (reset),
    .load  (skid_load),
    .clear (skid_clr),
    .d     (in_beat),
    .q     (skid_q)
  );

  assign out_data = out_valid ? main_q[SLOT_W-1 -: DATA_W] : '0;
  assign out_pc   = out_valid ? main_q[EXC_W+1 +: 32]      : bubble_pc;
  assign out_exc  = out_valid ? main_q[1 +: EXC_W]         : '0;
  assign out_bd   = out_valid ? main_q[0]                  : bubble_bd;

`ifdef PIPE_STATS_EN
  logic [31:0] stall_cnt, kill_cnt;

  // Counters survive a flush; only reset clears them
  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cnt <= '0;
      kill_cnt  <= '0;
    end else begin
      if (out_valid && !out_ready) stall_cnt <= wrap_inc(stall_cnt);
      if (kill_hs && !req)         kill_cnt  <= wrap_inc(kill_cnt);
    end
  end

  assign stat_stall = stall_cnt;
  assign stat_kill  = kill_cnt;
`else
  assign stat_stall = 32'd0;
  assign stat_kill  = 32'd0;
`endif

endmodule
